// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU control unit: state encodings, opcodes,
// mux select codes and the bundled control-strobe record.
package stack_cpu_pkg;

    typedef enum logic [4:0] {
        ST_RESET  = 5'd0,
        ST_FETCH  = 5'd1,
        ST_DECODE = 5'd2,
        ST_POPA   = 5'd3,
        ST_POPB   = 5'd4,
        ST_ALU    = 5'd5,
        ST_PUSH   = 5'd6,
        ST_IMM    = 5'd7,
        ST_LDRD   = 5'd8,
        ST_LDRES  = 5'd9,
        ST_STWR   = 5'd10,
        ST_JZTEST = 5'd11,
        ST_JUMP   = 5'd12,
        ST_CALL   = 5'd13,
        ST_RETRD  = 5'd14,
        ST_RETPC  = 5'd15,
        ST_HALT   = 5'd16
    } state_t;

    localparam logic [3:0] OP_PUSHI = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JUMP  = 4'hC;
    localparam logic [3:0] OP_CALL  = 4'hD;
    localparam logic [3:0] OP_RET   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] DST_PC   = 2'd0;
    localparam logic [1:0] DST_MSP  = 2'd1;
    localparam logic [1:0] DST_RSP  = 2'd2;
    localparam logic [1:0] DST_VALA = 2'd3;

    localparam logic [2:0] DATA_RES  = 3'd0;
    localparam logic [2:0] DATA_PC   = 3'd1;
    localparam logic [2:0] DATA_VALB = 3'd2;

    localparam logic [3:0] ALU_PASSA = 4'd8;
    localparam logic [3:0] ALU_PASSB = 4'd9;

    typedef struct packed {
        logic       msp_write;
        logic       msp_pop;
        logic       rsp_write;
        logic       rsp_pop;
        logic       pc_write;
        logic       pc_source;
        logic       pc_add;
        logic       vala_write;
        logic       valb_write;
        logic       ir_write;
        logic       mem_read1;
        logic       mem_read2;
        logic       mem_write1;
        logic       mem_write2;
        logic       res_source;
        logic       res_write;
        logic [1:0] mem_dst1;
        logic [1:0] mem_dst2;
        logic [2:0] mem_data;
        logic [3:0] alu_op;
    } ctrl_t;

    // Opcodes 0x0-0x7 are the binary ALU operations.
    function automatic logic is_alu_op(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/stack_cpu_decode.sv
// Combinational state-to-strobe decode; the only input besides the state are
// the ALU function bits and the zero flag used by the conditional branch.
module stack_cpu_decode
    import stack_cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] alu_func,
    input  logic       is_zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read1 = 1'b1;
                ctrl.mem_dst1  = DST_PC;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_add    = 1'b1;
            end
            ST_POPA, ST_POPB: begin
                ctrl.mem_read1  = 1'b1;
                ctrl.mem_dst1   = DST_MSP;
                ctrl.vala_write = (state == ST_POPA);
                ctrl.valb_write = (state == ST_POPB);
                ctrl.msp_write  = 1'b1;
                ctrl.msp_pop    = 1'b1;
            end
            ST_ALU: begin
                ctrl.alu_op    = {1'b0, alu_func};
                ctrl.res_write = 1'b1;
            end
            ST_PUSH: begin
                ctrl.mem_write1 = 1'b1;
                ctrl.mem_dst1   = DST_MSP;
                ctrl.mem_data   = DATA_RES;
                ctrl.msp_write  = 1'b1;
            end
            ST_IMM: begin
                ctrl.res_write  = 1'b1;
                ctrl.res_source = 1'b1;
            end
            ST_LDRD: begin
                ctrl.mem_read2  = 1'b1;
                ctrl.mem_dst2   = DST_VALA;
                ctrl.valb_write = 1'b1;
            end
            ST_LDRES: begin
                ctrl.alu_op    = ALU_PASSB;
                ctrl.res_write = 1'b1;
            end
            ST_STWR: begin
                ctrl.mem_write1 = 1'b1;
                ctrl.mem_dst1   = DST_VALA;
                ctrl.mem_data   = DATA_VALB;
            end
            // Conditional branch: the PC load is the one Mealy output.
            ST_JZTEST: begin
                ctrl.alu_op    = ALU_PASSA;
                ctrl.pc_write  = is_zero;
                ctrl.pc_source = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 1'b1;
            end
            ST_CALL: begin
                ctrl.mem_write2 = 1'b1;
                ctrl.mem_dst2   = DST_RSP;
                ctrl.mem_data   = DATA_PC;
                ctrl.rsp_write  = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 1'b1;
            end
            ST_RETRD: begin
                ctrl.mem_read2  = 1'b1;
                ctrl.mem_dst2   = DST_RSP;
                ctrl.valb_write = 1'b1;
                ctrl.rsp_write  = 1'b1;
                ctrl.rsp_pop    = 1'b1;
            end
            ST_RETPC: begin
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_cpu_control.sv
// Multi-cycle control unit for the 16-bit stack CPU: state register and
// opcode-driven next-state logic; strobes come from stack_cpu_decode.
module stack_cpu_control
    import stack_cpu_pkg::*;
#(
    parameter int STATE_W = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [15:0]        IROut,
    input  logic               isZero,
    output logic               MSPWrite,
    output logic               MSPop,
    output logic               RSPWrite,
    output logic               RSPop,
    output logic               PCWrite,
    output logic               PCSource,
    output logic               PCAdd,
    output logic               ValAWrite,
    output logic               ValBWrite,
    output logic               IRWrite,
    output logic               MemRead1,
    output logic               MemRead2,
    output logic               MemWrite1,
    output logic               MemWrite2,
    output logic               ResSource,
    output logic               ResWrite,
    output logic [1:0]         MemDst1,
    output logic [1:0]         MemDst2,
    output logic [2:0]         MemData,
    output logic [3:0]         ALUop,
    output logic [STATE_W-1:0] CurrentState,
    output logic [STATE_W-1:0] NextState
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    logic [3:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = IROut[15:12];
    assign unused_ir_bits = ^IROut[11:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_RESET;
        else        state <= next_state;
    end

    // Unreachable combinations and illegal encodings fall back to RESET.
    always_comb begin
        next_state = ST_RESET;
        case (state)
            ST_RESET:  next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: begin
                if (is_alu_op(opcode)) next_state = ST_POPB;
                else begin
                    case (opcode)
                        OP_PUSHI:               next_state = ST_IMM;
                        OP_LOAD, OP_STORE, OP_JZ: next_state = ST_POPA;
                        OP_JUMP:                next_state = ST_JUMP;
                        OP_CALL:                next_state = ST_CALL;
                        OP_RET:                 next_state = ST_RETRD;
                        default:                next_state = ST_HALT;
                    endcase
                end
            end
            ST_POPA: begin
                if (is_alu_op(opcode))     next_state = ST_ALU;
                else if (opcode == OP_LOAD)  next_state = ST_LDRD;
                else if (opcode == OP_STORE) next_state = ST_POPB;
                else if (opcode == OP_JZ)    next_state = ST_JZTEST;
            end
            ST_POPB: begin
                if (is_alu_op(opcode))     next_state = ST_POPA;
                else if (opcode == OP_STORE) next_state = ST_STWR;
            end
            ST_ALU:    next_state = ST_PUSH;
            ST_PUSH:   next_state = ST_FETCH;
            ST_IMM:    next_state = ST_PUSH;
            ST_LDRD:   next_state = ST_LDRES;
            ST_LDRES:  next_state = ST_PUSH;
            ST_STWR:   next_state = ST_FETCH;
            ST_JZTEST: next_state = ST_FETCH;
            ST_JUMP:   next_state = ST_FETCH;
            ST_CALL:   next_state = ST_FETCH;
            ST_RETRD:  next_state = ST_RETPC;
            ST_RETPC:  next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_RESET;
        endcase
    end

    stack_cpu_decode u_decode (
        .state    (state),
        .alu_func (IROut[14:12]),
        .is_zero  (isZero),
        .ctrl     (ctrl)
    );

    assign MSPWrite     = ctrl.msp_write;
    assign MSPop        = ctrl.msp_pop;
    assign RSPWrite     = ctrl.rsp_write;
    assign RSPop        = ctrl.rsp_pop;
    assign PCWrite      = ctrl.pc_write;
    assign PCSource     = ctrl.pc_source;
    assign PCAdd        = ctrl.pc_add;
    assign ValAWrite    = ctrl.vala_write;
    assign ValBWrite    = ctrl.valb_write;
    assign IRWrite      = ctrl.ir_write;
    assign MemRead1     = ctrl.mem_read1;
    assign MemRead2     = ctrl.mem_read2;
    assign MemWrite1    = ctrl.mem_write1;
    assign MemWrite2    = ctrl.mem_write2;
    assign ResSource    = ctrl.res_source;
    assign ResWrite     = ctrl.res_write;
    assign MemDst1      = ctrl.mem_dst1;
    assign MemDst2      = ctrl.mem_dst2;
    assign MemData      = ctrl.mem_data;
    assign ALUop        = ctrl.alu_op;
    assign CurrentState = STATE_W'(state);
    assign NextState    = STATE_W'(next_state);

endmodule

// File: tb/tb_stack_cpu_control.sv
// Directed self-checking bench for stack_cpu_control: walks each instruction
// class through its state sequence and checks every strobe in every state.
module tb_stack_cpu_control;

    logic        CLK;
    logic        RST_N;
    logic [15:0] IROut;
    logic        isZero;
    logic MSPWrite, MSPop, RSPWrite, RSPop, PCWrite, PCSource, PCAdd;
    logic ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2;
    logic ResSource, ResWrite;
    logic [1:0] MemDst1, MemDst2;
    logic [2:0] MemData;
    logic [3:0] ALUop;
    logic [4:0] CurrentState, NextState;

    int nAsserts = 0;
    int nFails   = 0;
    int seqBuf[8];

    // Bit positions of each output inside the packed observation vector.
    localparam int MSPW = 26, MSPP = 25, RSPW = 24, RSPP = 23, PCW = 22, PCS = 21;
    localparam int PCA = 20, VAW = 19, VBW = 18, IRW = 17, MR1 = 16, MR2 = 15;
    localparam int MW1 = 14, MW2 = 13, RSRC = 12, RESW = 11;

    logic [26:0] allOut;
    assign allOut = {MSPWrite, MSPop, RSPWrite, RSPop, PCWrite, PCSource, PCAdd,
                     ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1,
                     MemWrite2, ResSource, ResWrite, MemDst1, MemDst2, MemData, ALUop};

    stack_cpu_control #(.STATE_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .IROut(IROut), .isZero(isZero),
        .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
        .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
        .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
        .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1),
        .MemWrite2(MemWrite2), .ResSource(ResSource), .ResWrite(ResWrite),
        .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData), .ALUop(ALUop),
        .CurrentState(CurrentState), .NextState(NextState)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected strobe vector for a state, written straight from the state table.
    function automatic logic [26:0] expectedFor(input int st, input logic [2:0] aluBits,
                                                input logic z);
        logic [26:0] e;
        e = '0;
        case (st)
            1:  begin e[MR1] = 1; e[IRW] = 1; e[PCW] = 1; e[PCA] = 1; end
            3:  begin e[MR1] = 1; e[10:9] = 2'd1; e[VAW] = 1; e[MSPW] = 1; e[MSPP] = 1; end
            4:  begin e[MR1] = 1; e[10:9] = 2'd1; e[VBW] = 1; e[MSPW] = 1; e[MSPP] = 1; end
            5:  begin e[3:0] = {1'b0, aluBits}; e[RESW] = 1; end
            6:  begin e[MW1] = 1; e[10:9] = 2'd1; e[MSPW] = 1; end
            7:  begin e[RESW] = 1; e[RSRC] = 1; end
            8:  begin e[MR2] = 1; e[8:7] = 2'd3; e[VBW] = 1; end
            9:  begin e[3:0] = 4'd9; e[RESW] = 1; end
            10: begin e[MW1] = 1; e[10:9] = 2'd3; e[6:4] = 3'd2; end
            11: begin e[3:0] = 4'd8; e[PCS] = 1; e[PCW] = z; end
            12: begin e[PCW] = 1; e[PCS] = 1; end
            13: begin e[MW2] = 1; e[8:7] = 2'd2; e[6:4] = 3'd1; e[RSPW] = 1;
                      e[PCW] = 1; e[PCS] = 1; end
            14: begin e[MR2] = 1; e[8:7] = 2'd2; e[VBW] = 1; e[RSPW] = 1; e[RSPP] = 1; end
            15: begin e[PCW] = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one instruction from a FETCH-aligned negedge; seqBuf holds the
    // expected states, and the state after the last entry is always FETCH.
    task automatic applyStimulus(input string tag, input logic [15:0] ir, input logic z,
                                 input int len);
        int nxt;
        IROut  = ir;
        isZero = z;
        for (int i = 0; i < len; i++) begin
            nxt = (i == len - 1) ? 1 : seqBuf[i + 1];
            checkOutput($sformatf("%s step%0d state", tag, i), 32'(CurrentState), seqBuf[i]);
            checkOutput($sformatf("%s step%0d next", tag, i), 32'(NextState), nxt);
            checkOutput($sformatf("%s step%0d strobes", tag, i), 32'(allOut),
                        32'(expectedFor(seqBuf[i], ir[14:12], z)));
            @(negedge CLK);
        end
    endtask

    initial begin
        RST_N  = 1'b0;
        IROut  = 16'h0000;
        isZero = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset state", 32'(CurrentState), 0);
        checkOutput("reset next", 32'(NextState), 1);
        checkOutput("reset strobes", 32'(allOut), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        seqBuf = '{1, 2, 4, 3, 5, 6, 0, 0};
        applyStimulus("ADD", 16'h0000, 1'b0, 6);
        applyStimulus("ALU5", 16'h5000, 1'b1, 6);
        seqBuf = '{1, 2, 7, 6, 0, 0, 0, 0};
        applyStimulus("PUSHI", 16'h8123, 1'b0, 4);
        seqBuf = '{1, 2, 3, 8, 9, 6, 0, 0};
        applyStimulus("LOAD", 16'h9000, 1'b0, 6);
        seqBuf = '{1, 2, 3, 4, 10, 0, 0, 0};
        applyStimulus("STORE", 16'hA000, 1'b0, 5);
        seqBuf = '{1, 2, 3, 11, 0, 0, 0, 0};
        applyStimulus("JZ taken", 16'hB005, 1'b1, 4);
        applyStimulus("JZ not taken", 16'hB005, 1'b0, 4);
        seqBuf = '{1, 2, 12, 0, 0, 0, 0, 0};
        applyStimulus("JUMP", 16'hC000, 1'b0, 3);
        seqBuf = '{1, 2, 13, 0, 0, 0, 0, 0};
        applyStimulus("CALL", 16'hD010, 1'b0, 3);
        seqBuf = '{1, 2, 14, 15, 0, 0, 0, 0};
        applyStimulus("RET", 16'hE000, 1'b0, 4);

        // Abort a LOAD while it is reading memory in LDRD.
        IROut = 16'h9000;
        repeat (3) @(negedge CLK);
        checkOutput("midload in LDRD", 32'(CurrentState), 8);
        RST_N = 1'b0;
        #1;
        checkOutput("midload reset state", 32'(CurrentState), 0);
        checkOutput("midload reset next", 32'(NextState), 1);
        checkOutput("midload reset strobes", 32'(allOut), 0);
        @(negedge CLK);
        checkOutput("midload held state", 32'(CurrentState), 0);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("post reset fetch", 32'(CurrentState), 1);

        IROut = 16'hF000;
        @(negedge CLK);
        checkOutput("HALT decode", 32'(CurrentState), 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            isZero = i[0];
            checkOutput($sformatf("HALT cycle%0d state", i), 32'(CurrentState), 16);
            checkOutput($sformatf("HALT cycle%0d strobes", i), 32'(allOut), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/stack_cpu_control.md
# stack_cpu_control

Multi-cycle control unit for the 16-bit stack CPU. It decodes the opcode held in the instruction register and sequences a 17-state Moore/Mealy FSM. The FSM drives every datapath control strobe consumed by the stage-6 datapath and stage-4 memory/ALU integration. It sits directly upstream of that datapath and closes the loop on `isZero` and `IROut`.

## Interface
Parameters:
- `STATE_W`, 5: width of the state encoding and of the state debug ports.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IROut` in 16: instruction register. Opcode is `IROut[15:12]`.
- `isZero` in 1: ALU result-equals-zero flag, combinational from the datapath.
- `MSPWrite`, `MSPop` out 1 each: main-stack pointer update enable and direction (1 = pop, 0 = push).
- `RSPWrite`, `RSPop` out 1 each: return-stack pointer update enable and direction.
- `PCWrite`, `PCSource`, `PCAdd` out 1 each: PC load enable and next-PC select (see Operation).
- `ValAWrite`, `ValBWrite`, `IRWrite` out 1 each: register load enables.
- `MemRead1`, `MemRead2`, `MemWrite1`, `MemWrite2` out 1 each: memory port strobes.
- `ResSource`, `ResWrite` out 1 each: result select (0 = ALU, 1 = `SignExtOut`) and result load enable.
- `MemDst1`, `MemDst2` out 2 each: address select (0 = PC, 1 = MSP, 2 = RSP, 3 = ValA).
- `MemData` out 3: write-data select (0 = Res, 1 = PC, 2 = ValB; 3–7 reserved, never driven).
- `ALUop` out 4: 0–7 = `IROut[14:12]`; 8 = PASSA; 9 = PASSB.
- `CurrentState`, `NextState` out 5: debug view of the FSM.

## Operation
Next-PC select:
- `PCSource=1`: jump target (IR immediate).
- `PCSource=0`, `PCAdd=1`: PC+1.
- `PCSource=0`, `PCAdd=0`: ValB.

Opcodes:
- 0x0–0x7: binary ALU op. Pop B, pop A, push A op B.
- 0x8: PUSHI.
- 0x9: LOAD.
- 0xA: STORE. Top of stack is the address, next entry is the data.
- 0xB: JZ. Pop, branch if zero.
- 0xC: JUMP.
- 0xD: CALL.
- 0xE: RET.
- 0xF: HALT.

States and the strobes asserted in each. Every strobe not listed is 0.
- 0 RESET: nothing asserted → FETCH.
- 1 FETCH: `MemRead1`, `MemDst1=0`, `IRWrite`, `PCWrite`, `PCAdd` → DECODE.
- 2 DECODE: nothing asserted. Next state by opcode:
  - ALU ops → POPB.
  - PUSHI → IMM.
  - LOAD, STORE, JZ → POPA.
  - JUMP → JUMP; CALL → CALL; RET → RETRD; HALT → HALT.
- 3 POPA: `MemRead1`, `MemDst1=1`, `ValAWrite`, `MSPWrite`, `MSPop`. Next by opcode:
  - ALU op → ALU.
  - LOAD → LDRD.
  - STORE → POPB.
  - JZ → JZTEST.
- 4 POPB: same strobes with `ValBWrite` instead of `ValAWrite`. Next: ALU op → POPA; STORE → STWR.
- 5 ALU: `ALUop=IROut[14:12]`, `ResWrite`, `ResSource=0` → PUSH.
- 6 PUSH: `MemWrite1`, `MemDst1=1`, `MemData=0`, `MSPWrite`, `MSPop=0` → FETCH.
- 7 IMM: `ResWrite`, `ResSource=1` → PUSH.
- 8 LDRD: `MemRead2`, `MemDst2=3`, `ValBWrite` → LDRES.
- 9 LDRES: `ALUop=9`, `ResWrite` → PUSH.
- 10 STWR: `MemWrite1`, `MemDst1=3`, `MemData=2` → FETCH.
- 11 JZTEST: `ALUop=8`. `PCWrite=isZero`, `PCSource=1`. This is the only Mealy output. → FETCH.
- 12 JUMP: `PCWrite`, `PCSource=1` → FETCH.
- 13 CALL: `MemWrite2`, `MemDst2=2`, `MemData=1`, `RSPWrite`, `RSPop=0`, plus `PCWrite`, `PCSource=1` in the same cycle. The old PC is the value written. → FETCH.
- 14 RETRD: `MemRead2`, `MemDst2=2`, `ValBWrite`, `RSPWrite`, `RSPop` → RETPC.
- 15 RETPC: `PCWrite`, `PCSource=0`, `PCAdd=0` → FETCH.
- 16 HALT: nothing asserted. Stays in HALT until reset.

Unused encodings 17–31 → RESET on the next edge.

## Timing
- On `RST_N` low: state is forced to RESET immediately, without waiting for a clock edge. All strobes and `ALUop` are 0; `CurrentState=0`, `NextState=1`. This holds even when reset lands mid-instruction. No partial write is issued after reset is asserted.
- The first FETCH occurs in the first full cycle after reset is released.
- All outputs are decoded combinationally from the registered state. `JZTEST.PCWrite` additionally depends on `isZero`.
- Cycle counts, FETCH through the return to FETCH:
  - ALU: 6.
  - PUSHI: 4.
  - LOAD: 6.
  - STORE: 5.
  - JZ: 4.
  - JUMP, CALL: 3.
  - RET: 4.
- Memory reads return data by the end of the asserting cycle. The FSM never waits.

## Structure
- Shared package `stack_cpu_pkg`, holding:
  - State encodings.
  - Opcode constants.
  - `MemDst` codes, `MemData` codes.
  - `ALUop` constants including PASSA and PASSB.
- Sub-module `stack_cpu_decode`: pure combinational state → strobe decode.
- Top level holds only the state register and the next-state logic.

## Test plan
- Reset mid-LOAD in LDRD: drive `RST_N` low → all strobes 0 the same cycle, `CurrentState=0`. Release → FETCH one cycle later.
- ADD, `IROut=0x0000`: state sequence 1, 2, 4, 3, 5, 6, 1. `ALUop=0` in state 5. In PUSH: `MemWrite1=1`, `MSPop=0`, `MemData=0`.
- JZ `0xB005` with `isZero=1`: `PCWrite=1`, `PCSource=1` in JZTEST. Repeat with `isZero=0` → `PCWrite=0`. Both return to FETCH.
- CALL `0xD010` then RET `0xE000`:
  - CALL cycle: `MemWrite2`, `MemDst2=2`, `MemData=1`, `RSPWrite`, `PCWrite`, `PCSource=1`.
  - RETRD: `RSPop=1`.
  - RETPC: `PCSource=0`, `PCAdd=0`.
- STORE `0xA000`: sequence 1, 2, 3, 4, 10. STWR drives `MemDst1=3`, `MemData=2`.
- HALT `0xF000`: stays in state 16 for 20 cycles with all strobes 0.
